// File: rtl/xalu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xalu_pkg : shared types and constants for the XALU multiply/divide unit.
// Rev 1.0
// ----------------------------------------------------------------------------
package xalu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MUL   = 3'd7
  } xalu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } xalu_state_e;

  localparam int DIV_ITER = 32;

  function automatic logic [31:0] xalu_cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xalu_div_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xalu_div_core : unsigned radix-2 restoring divider, one bit per cycle.
// Rev 1.0
// ----------------------------------------------------------------------------
module xalu_div_core
  import xalu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  logic [5:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_ge;

  // Dividend shifts out of r_quo while quotient bits shift in behind it.
  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  assign w_ge     = ~w_diff[32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 6'd0;
      r_quo <= 32'd0;
      r_rem <= 32'd0;
      r_div <= 32'd0;
    end else if (i_start) begin
      r_cnt <= 6'(DIV_ITER);
      r_quo <= i_dividend;
      r_rem <= 32'd0;
      r_div <= i_divisor;
    end else if (r_cnt != 6'd0) begin
      r_rem <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
      r_quo <= {r_quo[30:0], w_ge};
      r_cnt <= r_cnt - 6'd1;
    end
  end

  // o_done marks the final iteration; results are valid the following cycle.
  assign o_busy      = (r_cnt != 6'd0);
  assign o_done      = (r_cnt == 6'd1);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/xalu_muldiv.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xalu_muldiv : EX-stage multi-cycle multiply/divide unit owning HI/LO.
// Define XALU_MUL_1CYC_EN for a single-cycle multiplier.  Rev 1.0
// ----------------------------------------------------------------------------
module xalu_muldiv
  import xalu_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_result
);

  xalu_op_e    w_op;
  xalu_state_e r_state;
  xalu_state_e w_next;
  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_mul_enter;
  logic        w_mul_fire;
  logic        w_mul_last;
  logic [31:0] w_mul_a;
  logic [31:0] w_mul_b;
  xalu_op_e    w_mul_op;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        w_div_busy;
  logic        w_div_done;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_op     = xalu_op_e'(op);
  assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU) || (w_op == OP_MUL);
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_accept = start && !flush && (r_state == ST_IDLE) && (w_op != OP_NONE);

`ifdef XALU_MUL_1CYC_EN
  assign w_mul_a     = src_a;
  assign w_mul_b     = src_b;
  assign w_mul_op    = w_op;
  assign w_mul_enter = 1'b0;
  assign w_mul_fire  = w_accept && w_is_mul;
  assign w_mul_last  = 1'b1;
`else
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  xalu_op_e    r_mul_op;
  logic [7:0]  r_cnt;

  // Operands are registered at accept so the multiplier sees a clean launch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mul_a  <= 32'd0;
      r_mul_b  <= 32'd0;
      r_mul_op <= OP_NONE;
      r_cnt    <= 8'd0;
    end else if (w_accept && w_is_mul) begin
      r_mul_a  <= src_a;
      r_mul_b  <= src_b;
      r_mul_op <= w_op;
      r_cnt    <= 8'(MUL_LAT - 2);
    end else if ((r_state == ST_MUL) && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign w_mul_a     = r_mul_a;
  assign w_mul_b     = r_mul_b;
  assign w_mul_op    = r_mul_op;
  assign w_mul_enter = w_accept && w_is_mul;
  assign w_mul_fire  = (r_state == ST_MUL) && (r_cnt == 8'd0);
  assign w_mul_last  = (r_cnt == 8'd0);
`endif

  // Extension choice makes the low 64 bits right for signed and unsigned alike.
  assign w_ext_a = (w_mul_op == OP_MULTU) ? {32'd0, w_mul_a} : {{32{w_mul_a[31]}}, w_mul_a};
  assign w_ext_b = (w_mul_op == OP_MULTU) ? {32'd0, w_mul_b} : {{32{w_mul_b[31]}}, w_mul_b};
  assign w_prod  = w_ext_a * w_ext_b;

  xalu_div_core u_div (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (w_accept && w_is_div),
    .i_dividend  (xalu_cond_neg(src_a, (w_op == OP_DIV) && src_a[31])),
    .i_divisor   (xalu_cond_neg(src_b, (w_op == OP_DIV) && src_b[31])),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_div) w_next = ST_DIV;
        else if (w_mul_enter)     w_next = ST_MUL;
      end
      ST_MUL:  if (w_mul_last) w_next = ST_IDLE;
      ST_DIV:  if (w_div_done) w_next = ST_FIX;
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    done = w_mul_fire || (r_state == ST_FIX);
  end

  // Sign fixup: quotient negative on differing signs, remainder follows dividend.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      mul_result <= 32'd0;
    end else begin
      if (w_accept && w_is_div) begin
        r_neg_q <= (w_op == OP_DIV) && (src_a[31] ^ src_b[31]);
        r_neg_r <= (w_op == OP_DIV) && src_a[31];
      end
      if (w_accept && (w_op == OP_MTHI)) hi <= src_a;
      if (w_accept && (w_op == OP_MTLO)) lo <= src_a;
      if (w_mul_fire) begin
        if (w_mul_op == OP_MUL) begin
          mul_result <= w_prod[31:0];
        end else begin
          hi <= w_prod[63:32];
          lo <= w_prod[31:0];
        end
      end
      if (r_state == ST_FIX) begin
        lo <= xalu_cond_neg(w_quo, r_neg_q);
        hi <= xalu_cond_neg(w_rem, r_neg_r);
      end
    end
  end

`ifndef SYNTHESIS
  a_issue_only_when_idle: assert property (@(posedge clk) disable iff (!resetn)
    (start && !flush && (op != 3'd0)) |-> (r_state == ST_IDLE));
  a_div_core_in_step: assert property (@(posedge clk) disable iff (!resetn)
    (r_state == ST_DIV) |-> w_div_busy);
`endif

endmodule
`default_nettype wire

// File: tb/tb_xalu_muldiv.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_xalu_muldiv : directed and randomized checks of xalu_muldiv against an
// arithmetic reference model.  Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xalu_muldiv;

  localparam int MUL_LAT  = 3;
  localparam int DIV_BUSY = 33;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mul_result;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: architectural regs plus one pending result.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_mr = 32'd0;
  logic [31:0] p_hi = 32'd0, p_lo = 32'd0, p_mr = 32'd0;
  bit          p_is_mr = 1'b0;
  int          m_left = 0;

  xalu_muldiv #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .mul_result (mul_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      3'd1, 3'd2, 3'd7: begin
        if (o == 3'd2) prod = {32'd0, a} * {32'd0, b};
        else           prod = sa * sb;
        p_hi = prod[63:32];
        p_lo = prod[31:0];
        p_mr = prod[31:0];
        p_is_mr = (o == 3'd7);
        m_left = MUL_LAT - 1;
      end
      3'd3: begin
        if (b == 32'd0) begin
          p_lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
          p_hi = a;
        end else begin
          p_lo = 32'(sa / sb);
          p_hi = 32'(sa % sb);
        end
        p_is_mr = 1'b0;
        m_left = DIV_BUSY;
      end
      3'd4: begin
        if (b == 32'd0) begin
          p_lo = 32'hFFFF_FFFF;
          p_hi = a;
        end else begin
          p_lo = a / b;
          p_hi = a % b;
        end
        p_is_mr = 1'b0;
        m_left = DIV_BUSY;
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_hi = 32'd0; m_lo = 32'd0; m_mr = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        if (p_is_mr) m_mr = p_mr;
        else begin m_hi = p_hi; m_lo = p_lo; end
      end
      m_left--;
    end else if (start && !flush && (op != 3'd0)) begin
      model_accept(op, src_a, src_b);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("done", {31'd0, done}, {31'd0, (m_left == 1)});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("mul_result", mul_result, m_mr);
  end

  // Called at posedge+2 of an idle cycle; returns at posedge+2 of the first idle cycle after.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bc, output int dc);
    bit ended;
    start = 1'b1; flush = 1'b0; op = o; src_a = a; src_b = b;
    @(posedge clk); #2;
    start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    bc = 0; dc = 0; ended = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy) bc++;
      if (done) dc++;
      if (!busy) begin ended = 1'b1; break; end
      flush = 1'($urandom_range(0, 1));
      start = flush & 1'($urandom_range(0, 1));
      op = 3'($urandom); src_a = $urandom; src_b = $urandom;
      @(posedge clk); #2;
    end
    start = 1'b0; flush = 1'b0;
    if (!ended) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: busy still %b after 60 cycles, required 0", busy);
    end
  endtask

  initial begin
    int bc, dc;
    logic [2:0]  o;
    logic [31:0] a, b;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mr", mul_result, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #2;

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, bc, dc);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_busy_cycles", bc, 32'd2);
    chk("mult_done_pulses", dc, 32'd1);

    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    run_op(3'd7, 32'd7, 32'd6, bc, dc);
    chk("mul_result", mul_result, 32'd42);
    chk("mul_hi_kept", hi, 32'hFFFF_FFFE);
    chk("mul_lo_kept", lo, 32'h0000_0001);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, bc, dc);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_busy_cycles", bc, 32'd33);
    chk("div_done_pulses", dc, 32'd1);

    run_op(3'd4, 32'd100, 32'd7, bc, dc);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    run_op(3'd3, 32'd5, 32'd0, bc, dc);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    start = 1'b1; flush = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #2;
    start = 1'b0; flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_lo_kept", lo, 32'h8000_0000);

    start = 1'b1; op = 3'd4; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #2; end
    resetn = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #2;

    run_op(3'd6, 32'h0000_1234, 32'd0, bc, dc);
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_busy_cycles", bc, 32'd0);
    chk("mtlo_done_pulses", dc, 32'd0);

    for (int k = 0; k < 250; k++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(0, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        start = 1'b1; flush = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #2;
        start = 1'b0; flush = 1'b0;
      end else begin
        run_op(o, a, b, bc, dc);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end

    @(posedge clk); #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
